// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encodings for the UART transceiver
package uart_pkg;

    localparam int CLK_FREQ     = 32_000_000;
    localparam int BAUD         = 115_200;
    localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver with input synchroniser, mid-bit sampling and one-cycle valid strobe
module uart_rx #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data_rx,
    output logic       valid
);
    import uart_pkg::*;

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             din_meta;
    logic             din_sync;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_meta <= 1'b1;
            din_sync <= 1'b1;
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            data_rx  <= '0;
            valid    <= 1'b0;
        end else begin
            din_meta <= din;
            din_sync <= din_meta;
            valid    <= 1'b0;
            case (rx_state)
                // IDLE is only entered with the line high, so a low here is a falling edge
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!din_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt      <= '0;
                        rx_state <= din_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {din_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (din_sync) begin
                            data_rx  <= shreg;
                            valid    <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (din_sync) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 transmitter; byte latched on accept, registered glitch-free dout
module uart_tx #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [7:0]          data_tx,
    output logic                rdy,
    output logic                dout,
    output uart_pkg::tx_state_t state
);
    import uart_pkg::*;

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TX_IDLE;
            dout    <= 1'b1;
            rdy     <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (en) begin
                        shreg <= data_tx;
                        state <= TX_START;
                        rdy   <= 1'b0;
                        dout  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                TX_START: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= TX_DATA;
                        dout    <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= TX_STOP;
                            dout  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            dout    <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= TX_IDLE;
                        rdy   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - 8N1 UART with independent receive and transmit paths
module uart_transceiver #(
    parameter int CLK_FREQ     = uart_pkg::CLK_FREQ,
    parameter int BAUD         = uart_pkg::BAUD,
    parameter int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data_rx,
    output logic       valid,
    input  logic       en,
    input  logic [7:0] data_tx,
    output logic       rdy,
    output logic       dout,
    output logic [1:0] state
);
    import uart_pkg::*;

    tx_state_t tx_state;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .data_rx (data_rx),
        .valid   (valid)
    );

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .data_tx (data_tx),
        .rdy     (rdy),
        .dout    (dout),
        .state   (tx_state)
    );

    assign state = tx_state;

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - echo-mode bench for uart_transceiver with rx/tx scoreboards
`timescale 1ns/1ps
module tb_uart_transceiver;

    localparam int  CPB      = 278;
    localparam int  HALF     = CPB / 2;
    localparam real BIT_NS   = 8680.5;
    localparam real SLOW_NS  = 8700.0;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic [7:0] data_rx;
    logic       valid;
    logic       en;
    logic [7:0] data_tx;
    logic       rdy;
    logic       dout;
    logic [1:0] state;
    logic       tb_en;
    logic [7:0] tb_data;

    int         checks = 0;
    int         errors = 0;
    int         tx_frames = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    real        t_start;
    real        cur_bit_ns = BIT_NS;
    real        rx_dt;
    bit         abort_tx = 1'b0;
    bit         tx_busy = 1'b0;
    bit         tx_aborted;
    int         tc;
    logic [7:0] tx_got;

    always #15.625 clk = ~clk;

    // echo wiring, with a side door for stray requests from the bench
    assign en      = valid | tb_en;
    assign data_tx = valid ? data_rx : tb_data;

    uart_transceiver dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .data_rx (data_rx),
        .valid   (valid),
        .en      (en),
        .data_tx (data_tx),
        .rdy     (rdy),
        .dout    (dout),
        .state   (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns,
                              input bit expect_ok);
        if (expect_ok) begin
            rx_exp.push_back(b);
            tx_exp.push_back(b);
        end
        t_start    = $realtime;
        cur_bit_ns = bit_ns;
        din = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            #(bit_ns);
        end
        din = stop_bit;
        #(bit_ns);
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while (!(rdy === 1'b1 && !tx_busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("tx_idle_timeout", n < 4000, 1);
        repeat (20) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dout"}, dout, 1);
        check({tag, "_rdy"}, rdy, 1);
        check({tag, "_state"}, state, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_data_rx"}, data_rx, 0);
    endtask

    initial begin : rx_mon
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                rx_dt = $realtime - t_start;
                check("rx_valid_time", (rx_dt > 9.4 * cur_bit_ns) && (rx_dt < 9.6 * cur_bit_ns), 1);
                check("rx_queue_nonempty", rx_exp.size() != 0, 1);
                if (rx_exp.size() != 0) check("rx_byte", data_rx, rx_exp.pop_front());
            end
        end
    end

    // samples each transmitted bit at its middle, counting negedges from the start-bit fall
    initial begin : tx_mon
        forever begin
            @(negedge clk);
            if (!abort_tx && rst === 1'b0 && dout === 1'b0) begin
                tx_busy    = 1'b1;
                tx_aborted = 1'b0;
                tc         = 0;
                tx_got     = '0;
                check("tx_rdy_low_at_start", rdy, 0);
                while (rdy !== 1'b1 && tc < 3000 && !tx_aborted) begin
                    @(negedge clk);
                    tc++;
                    if (abort_tx) begin
                        tx_aborted = 1'b1;
                    end else begin
                        if (tc == HALF) begin
                            check("tx_start_bit", dout, 0);
                            check("tx_state_start", state, 1);
                        end
                        if (tc >= HALF + CPB && tc <= HALF + 8 * CPB && (tc - HALF) % CPB == 0)
                            tx_got[(tc - HALF) / CPB - 1] = dout;
                        if (tc == HALF + CPB) check("tx_state_data", state, 2);
                        if (tc == HALF + 9 * CPB) begin
                            check("tx_stop_bit", dout, 1);
                            check("tx_state_stop", state, 3);
                        end
                    end
                end
                if (abort_tx) tx_aborted = 1'b1;
                if (!tx_aborted) begin
                    check("tx_frame_cycles", tc, 10 * CPB);
                    check("tx_state_idle", state, 0);
                    check("tx_queue_nonempty", tx_exp.size() != 0, 1);
                    if (tx_exp.size() != 0) check("tx_byte", tx_got, tx_exp.pop_front());
                    tx_frames++;
                end
                tx_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst     = 1'b1;
        din     = 1'b1;
        tb_en   = 1'b0;
        tb_data = 8'h00;
        #100;
        check_reset_values("reset_init");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        send_frame(8'h2A, 1'b1, BIT_NS, 1'b1);
        wait_tx_idle();

        // sender slightly slower than the transmitter so each echo ends before the next strobe
        send_frame(8'h2A, 1'b1, SLOW_NS, 1'b1);
        send_frame(8'h58, 1'b1, SLOW_NS, 1'b1);
        wait_tx_idle();

        din = 1'b0;
        repeat (50) @(posedge clk);
        din = 1'b1;
        #(3 * BIT_NS);
        check("glitch_data_rx_hold", data_rx, 8'h58);
        send_frame(8'h55, 1'b1, BIT_NS, 1'b1);
        wait_tx_idle();

        send_frame(8'hFF, 1'b0, BIT_NS, 1'b0);
        #(BIT_NS);
        din = 1'b1;
        #(2 * BIT_NS);
        check("framing_data_rx_hold", data_rx, 8'h55);
        send_frame(8'hA5, 1'b1, BIT_NS, 1'b1);
        check("busy_rdy_low", rdy, 0);
        @(negedge clk);
        tb_data = 8'h99;
        tb_en   = 1'b1;
        @(negedge clk);
        tb_en   = 1'b0;
        tb_data = 8'h00;
        wait_tx_idle();

        send_frame(8'h3C, 1'b1, BIT_NS, 1'b1);
        din = 1'b0;
        #(3 * BIT_NS);
        abort_tx = 1'b1;
        rst      = 1'b1;
        #1;
        check_reset_values("reset_mid");
        #39;
        din = 1'b1;
        rst = 1'b0;
        tx_exp.delete();
        repeat (5) @(negedge clk);
        abort_tx = 1'b0;
        #(12 * BIT_NS);
        check("reset_no_partial", data_rx, 0);
        check("reset_rdy_idle", rdy, 1);

        send_frame(8'h81, 1'b1, BIT_NS, 1'b1);
        wait_tx_idle();

        check("rx_queue_drained", rx_exp.size(), 0);
        check("tx_queue_drained", tx_exp.size(), 0);
        check("tx_frame_count", tx_frames, 6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
